// File: rtl/spi_pkg.sv
`default_nettype none
// +-------------------------------------------------------------+
// | spi_pkg : shared types/constants for the SPI channel arbiter |
// | Rev 1.0                                                      |
// +-------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } spi_arb_state_t;

  localparam int SPI_BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-------------------------------------------------------------+
// | rr_pick : first set request at or after ptr, wrapping        |
// | Rev 1.0                                                      |
// +-------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PTR_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------+
// | spi_arbiter : round-robin sharing of one SPI master channel  |
// | Rev 1.0                                                      |
// +-------------------------------------------------------------+
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = SPI_BYTE_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    m_tx_en,
  output logic [DATA_W-1:0]       m_tx_data,
  input  logic                    m_done,
  input  logic [DATA_W-1:0]       m_rx_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  spi_arb_state_t    r_state;
  spi_arb_state_t    w_next;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_win_idx;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [N_REQ-1:0]  w_pick_onehot;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_tmo_hit;
  logic [DATA_W-1:0] w_slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_slice[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .valid  (w_pick_valid)
  );

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = ARB;
      ARB:     w_next = w_pick_valid ? LAUNCH : IDLE;
      LAUNCH:  w_next = WAIT;
      WAIT:    if (m_done || w_tmo_hit) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_tmo_cnt <= '0;
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rx_data   <= '0;
      m_tx_en   <= 1'b0;
      m_tx_data <= '0;
    end else begin
      r_state <= w_next;
      m_tx_en <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_pick_valid) begin
            gnt       <= w_pick_onehot;
            r_win_idx <= w_pick_idx;
            m_tx_data <= w_slice[w_pick_idx];
          end
        end
        LAUNCH: begin
          m_tx_en   <= 1'b1;
          r_tmo_cnt <= '0;
        end
        WAIT: begin
          // A completion in the same cycle as the timeout is a clean finish.
          if (m_done) begin
            rx_data <= m_rx_data;
            ack     <= gnt;
          end else if (w_tmo_hit) begin
            ack <= gnt;
            err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ACK: begin
          gnt   <= '0;
          r_ptr <= (r_win_idx == PTR_W'(N_REQ - 1)) ? '0 : r_win_idx + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
